// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution pixel feeder path.
//   feeder_state_e : feeder scan FSM state encoding
//   MIN_DIM        : smallest plane dimension that yields a valid 3x3 window
//   DIM_W / K_W    : row/column counter width and push-index counter width,
//                    derived from the default maximum plane size
//   RD_CNT_W       : read down-counter width (holds a full width*height product)
//   dims_ok()      : start-time plane size qualifier
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_IMAGE_WIDTH  = 128;
  localparam int DEF_IMAGE_HEIGHT = 128;
  localparam int MIN_DIM          = 3;

  localparam int DIM_W =
    $clog2((DEF_IMAGE_WIDTH > DEF_IMAGE_HEIGHT) ? DEF_IMAGE_WIDTH : DEF_IMAGE_HEIGHT) + 1;
  localparam int K_W      = $clog2(DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT + 1);
  localparam int RD_CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  function automatic logic dims_ok(input logic [DIM_W-1:0] w,
                                   input logic [DIM_W-1:0] h,
                                   input int               w_max,
                                   input int               h_max);
    return (int'(w) >= MIN_DIM) && (int'(h) >= MIN_DIM) &&
           (int'(w) <= w_max)   && (int'(h) <= h_max);
  endfunction

endpackage

// File: rtl/feeder_centre_tracker.sv
// -----------------------------------------------------------------------------
// feeder_centre_tracker
// Follows the collector's centre tap as pixels are pushed and decodes the
// horizontal padding flags and the window qualifier for that centre.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            clears the push index and centre row/column (scan start)
//   push            a pixel enters the collector this cycle
//   width, height   latched plane size
//   stride2         1 = qualify only odd-row/odd-column centres
//   paddingl/r      centre column is first/last column (qualified windows only)
//   window_valid    collector holds a complete window for this centre
// -----------------------------------------------------------------------------
module feeder_centre_tracker
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             push,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             stride2,
  output logic             paddingl,
  output logic             paddingr,
  output logic             window_valid
);

  logic [K_W-1:0]   k_q, k_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;

  logic centre_live;
  logic row_inner;
  logic last_col;
  logic base_valid;
  logic stride_ok;

  always_comb begin
    // The centre only exists once W+1 pixels have entered the line buffers.
    centre_live  = k_q >= (K_W'(width) + K_W'(1));
    row_inner    = (row_q >= DIM_W'(1)) && (row_q <= (height - DIM_W'(2)));
    last_col     = col_q == (width - DIM_W'(1));
    base_valid   = push && centre_live && row_inner;
    stride_ok    = !stride2 || (row_q[0] && col_q[0]);

    window_valid = base_valid && stride_ok;
    // Padding only matters for windows that are actually captured downstream.
    paddingl     = base_valid && (col_q == '0);
    paddingr     = base_valid && last_col;

    k_d   = k_q;
    row_d = row_q;
    col_d = col_q;
    if (load) begin
      k_d   = '0;
      row_d = '0;
      col_d = '0;
    end else if (push) begin
      k_d = k_q + K_W'(1);
      if (centre_live) begin
        if (last_col) begin
          col_d = '0;
          row_d = row_q + DIM_W'(1);
        end else begin
          col_d = col_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      k_q   <= k_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_pixel_feeder.sv
// -----------------------------------------------------------------------------
// conv_pixel_feeder
// Raster-scans one image plane out of a synchronous-read pixel memory and
// pushes it, one pixel per enabled cycle, into the 3x3 collector. A trailing
// zero pixel completes the last window.
// Optional build macro: FEEDER_STRIDE2_EN adds the stride2 input (latched at
// start) which restricts window_valid to odd-row/odd-column centres.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse, begins a scan when idle and dimensions are legal
//   width, height       plane size, 3..IMAGE_WIDTH / 3..IMAGE_HEIGHT
//   base_addr           address of pixel (0,0)
//   hold                downstream stall
//   stride2             (FEEDER_STRIDE2_EN only) 2x2 decimation of window_valid
//   mem_rd_en/mem_addr  read request; mem_rdata returns one cycle later
//   pixel_out/pixel_en  pixel pushed to the collector this cycle
//   paddingl/paddingr   centre column is first/last column
//   window_valid        complete window available for the current centre
//   busy, done          scan in progress / end-of-scan pulse
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a legal start
// ST_FETCH | issuing reads base_addr .. base_addr+W*H-1 in raster order
// ST_FLUSH | draining the last read/skid entry, then pushing one zero pixel
// ST_DONE  | one-cycle done pulse
// -----------------------------------------------------------------------------
module conv_pixel_feeder
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        width,
  input  logic [7:0]        height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
`ifdef FEEDER_STRIDE2_EN
  input  logic              stride2,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel_out,
  output logic              pixel_en,
  output logic              paddingl,
  output logic              paddingr,
  output logic              window_valid,
  output logic              busy,
  output logic              done
);

  feeder_state_e        state_q, state_d;
  logic [DIM_W-1:0]     width_q, width_d;
  logic [DIM_W-1:0]     height_q, height_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [RD_CNT_W-1:0]  reads_left_q, reads_left_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 skid_full_q, skid_full_d;
  logic [7:0]           skid_data_q, skid_data_d;

  logic                 scan_load;
  logic                 flush_push;
  logic                 stride_sel;

`ifdef FEEDER_STRIDE2_EN
  logic stride_q, stride_d;
  assign stride_sel = stride_q;
`else
  assign stride_sel = 1'b0;
`endif

  always_comb begin
    mem_rd_en  = (state_q == ST_FETCH) && !hold && !skid_full_q;
    mem_addr   = addr_q;
    busy       = state_q != ST_IDLE;
    done       = state_q == ST_DONE;

    // The zero pixel goes out only once every fetched pixel has been pushed.
    flush_push = (state_q == ST_FLUSH) && !rd_pend_q && !skid_full_q && !hold;

    // mem_rdata is already the memory's output register, so it is forwarded
    // straight through in the cycle it is valid. The skid entry is older than
    // any in-flight read and always wins.
    pixel_en  = !hold && (skid_full_q || rd_pend_q || flush_push);
    pixel_out = '0;
    if (!hold) begin
      if (skid_full_q)    pixel_out = skid_data_q;
      else if (rd_pend_q) pixel_out = mem_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    addr_d       = addr_q;
    reads_left_d = reads_left_q;
    scan_load    = 1'b0;
`ifdef FEEDER_STRIDE2_EN
    stride_d     = stride_q;
`endif

    rd_pend_d   = mem_rd_en;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    if (hold && rd_pend_q) begin
      skid_full_d = 1'b1;
      skid_data_d = mem_rdata;
    end else if (!hold && skid_full_q) begin
      skid_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && dims_ok(width, height, IMAGE_WIDTH, IMAGE_HEIGHT)) begin
          width_d      = width;
          height_d     = height;
          addr_d       = base_addr;
          reads_left_d = RD_CNT_W'(width) * RD_CNT_W'(height);
          scan_load    = 1'b1;
`ifdef FEEDER_STRIDE2_EN
          stride_d     = stride2;
`endif
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rd_en) begin
          addr_d       = addr_q + ADDR_W'(1);
          reads_left_d = reads_left_q - RD_CNT_W'(1);
          if (reads_left_q == RD_CNT_W'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_push) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      addr_q       <= '0;
      reads_left_q <= '0;
      rd_pend_q    <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_data_q  <= '0;
`ifdef FEEDER_STRIDE2_EN
      stride_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      addr_q       <= addr_d;
      reads_left_q <= reads_left_d;
      rd_pend_q    <= rd_pend_d;
      skid_full_q  <= skid_full_d;
      skid_data_q  <= skid_data_d;
`ifdef FEEDER_STRIDE2_EN
      stride_q     <= stride_d;
`endif
    end
  end

  feeder_centre_tracker u_centre (
    .clk          (clk),
    .rst          (rst),
    .load         (scan_load),
    .push         (pixel_en),
    .width        (width_q),
    .height       (height_q),
    .stride2      (stride_sel),
    .paddingl     (paddingl),
    .paddingr     (paddingr),
    .window_valid (window_valid)
  );

endmodule

// File: tb/tb_conv_pixel_feeder.sv
module tb_conv_pixel_feeder;

  localparam int AW    = 14;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    width;
  logic [7:0]    height;
  logic [AW-1:0] base_addr;
  logic          hold;
  logic          stride2;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'd0;
  logic [7:0]    pixel_out;
  logic          pixel_en;
  logic          paddingl;
  logic          paddingr;
  logic          window_valid;
  logic          busy;
  logic          done;

  conv_pixel_feeder #(
    .IMAGE_WIDTH  (128),
    .IMAGE_HEIGHT (128),
    .ADDR_W       (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .width        (width),
    .height       (height),
    .base_addr    (base_addr),
    .hold         (hold),
`ifdef FEEDER_STRIDE2_EN
    .stride2      (stride2),
`endif
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .pixel_out    (pixel_out),
    .pixel_en     (pixel_en),
    .paddingl     (paddingl),
    .paddingr     (paddingr),
    .window_valid (window_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel memory.
  logic [7:0] mem [0:MSIZE-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] pix;
    logic       pl;
    logic       pr;
    logic       wv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int wv_cnt = 0;
  int done_cnt = 0;
  int exp_wv = 0;
  int exp_first_push = -1;
  int exp_done_cyc = -1;
  logic first_pending = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Reference model: pixel k of the push stream is memory word base+k (mod
  // 2^AW), then one zero. Push k sits on centre n = k-(W+1) at row n/W,
  // column n%W; only interior rows produce windows.
  task automatic model_scan(input int w, input int h, input int b, input bit st);
    exp_t e;
    int n, r, c;
    bit inner;
    exp_wv = 0;
    for (int k = 0; k <= w * h; k++) begin
      e.pix = (k < w * h) ? mem[(b + k) % MSIZE] : 8'd0;
      n = k - (w + 1);
      r = 0;
      c = 0;
      inner = 1'b0;
      if (n >= 0) begin
        r = n / w;
        c = n % w;
        inner = (r >= 1) && (r <= h - 2);
      end
      e.wv = inner && (!st || ((r % 2 == 1) && (c % 2 == 1)));
      e.pl = inner && (c == 0);
      e.pr = inner && (c == w - 1);
      if (e.wv) exp_wv++;
      sb.push_back(e);
    end
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        check("rd_en_during_hold", int'(mem_rd_en), 0);
        check("pixel_en_during_hold", int'(pixel_en), 0);
      end
      if (pixel_en) begin
        push_cnt++;
        if (window_valid) wv_cnt++;
        if (first_pending) begin
          check("first_push_cycle", cyc, exp_first_push);
          first_pending = 1'b0;
        end
        if (sb.size() == 0) begin
          fail_now("unexpected_push", $sformatf("pixel %0d with empty scoreboard", pixel_out));
        end else begin
          mon_e = sb.pop_front();
          check("pixel", int'(pixel_out), int'(mon_e.pix));
          check("paddingl", int'(paddingl), int'(mon_e.pl));
          check("paddingr", int'(paddingr), int'(mon_e.pr));
          check("window_valid", int'(window_valid), int'(mon_e.wv));
        end
      end else begin
        check("flags_without_push", int'({paddingl, paddingr, window_valid}), 0);
      end
      if (done) begin
        done_cnt++;
        check("pending_at_done", sb.size(), 0);
        if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
      end
    end
  end

  int push_base, wv_base;

  task automatic do_start(input int w, input int h, input int b, input bit st,
                          input bit accept, input bit timed);
    @(posedge clk); #1;
    width     = 8'(w);
    height    = 8'(h);
    base_addr = AW'(b);
    stride2   = st;
    start     = 1'b1;
    if (accept) begin
      push_base = push_cnt;
      wv_base   = wv_cnt;
`ifdef FEEDER_STRIDE2_EN
      model_scan(w, h, b, st);
`else
      model_scan(w, h, b, 1'b0);
`endif
      exp_first_push = cyc + 2;
      first_pending  = timed;
      exp_done_cyc   = timed ? cyc + w * h + 3 : -1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int hold_pct, input string name);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk); #1;
      hold = (hold_pct > 0) && (int'($urandom_range(0, 99)) < hold_pct);
      i++;
    end
    hold = 1'b0;
    if (done_cnt == d0) fail_now(name, "no done pulse within cycle budget");
  endtask

  task automatic finish_scan(input int w, input int h, input string name);
    repeat (3) @(negedge clk);
    check({name, "_push_count"}, push_cnt - push_base, w * h + 1);
    check({name, "_window_count"}, wv_cnt - wv_base, exp_wv);
    check({name, "_scoreboard_empty"}, sb.size(), 0);
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int d0, w, h;
    bit st;
    bit found;

    rst = 1'b1; start = 1'b0; hold = 1'b0; stride2 = 1'b0;
    width = 8'd0; height = 8'd0; base_addr = '0;
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);

    #1;
    check("reset_outputs",
          int'({pixel_en, pixel_out, mem_rd_en, mem_addr, paddingl, paddingr,
                window_valid, busy, done}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic 4x4 scan, pixels 1..16 then 0, exact timing.
    do_start(4, 4, 0, 1'b0, 1'b1, 1'b1);
    check("exp_window_count_4x4", exp_wv, 8);
    run_until_done(60, 0, "basic_4x4_done");
    finish_scan(4, 4, "basic_4x4");

    // Hold for 3 cycles right after pixel 6 is read.
    do_start(4, 4, 0, 1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == AW'(5)) found = 1'b1;
    end
    if (!found) fail_now("hold_trigger", "read of pixel 6 never seen");
    @(posedge clk); #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    run_until_done(60, 0, "hold_done");
    finish_scan(4, 4, "hold");

    // Illegal start is ignored.
    d0 = done_cnt;
    do_start(2, 4, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_after_bad_start", int'(busy), 0);
    end
    check("done_after_bad_start", done_cnt - d0, 0);

    // Start while busy is ignored.
    do_start(5, 4, 100, 1'b0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1 width = 8'd3; height = 8'd3; base_addr = AW'(7); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_until_done(80, 0, "busy_start_done");
    finish_scan(5, 4, "busy_start");

    // Reset mid-scan.
    do_start(4, 4, 0, 1'b0, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midscan_reset_outputs",
          int'({pixel_en, pixel_out, mem_rd_en, mem_addr, paddingl, paddingr,
                window_valid, busy, done}), 0);
    sb.delete();
    first_pending = 1'b0;
    exp_done_cyc = -1;
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("done_after_reset", done_cnt - d0, 0);
    check("busy_after_reset", int'(busy), 0);
    do_start(4, 4, 0, 1'b0, 1'b1, 1'b1);
    run_until_done(60, 0, "post_reset_done");
    finish_scan(4, 4, "post_reset");

    // Randomized scans with random stalls.
    for (int t = 0; t < 6; t++) begin
      w  = int'($urandom_range(3, 9));
      h  = int'($urandom_range(3, 9));
      st = 1'($urandom_range(0, 1));
      do_start(w, h, int'($urandom_range(0, MSIZE - 1)), st, 1'b1, 1'b0);
      run_until_done(600, 30, "random_done");
      finish_scan(w, h, "random");
    end

`ifdef FEEDER_STRIDE2_EN
    // 2x2 decimation on a 6x6 plane.
    do_start(6, 6, 40, 1'b1, 1'b1, 1'b1);
    check("exp_window_count_stride", exp_wv, 6);
    run_until_done(80, 0, "stride_done");
    finish_scan(6, 6, "stride");
`endif

    // Full-size plane with address wrap.
    do_start(128, 128, 16'h3F00, 1'b0, 1'b1, 1'b1);
    check("exp_window_count_128", exp_wv, 126 * 128);
    run_until_done(17000, 0, "full_done");
    finish_scan(128, 128, "full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
